// File: rtl/updown_counter_param_if.sv
// Control and status bundle of the modulo-N up/down counter.
// The master drives the controls; the slave (the counter) drives count and flags.
interface updown_counter_param_if #(
   parameter int WIDTH = 5
);
   logic             clr;
   logic             en;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             load_err;
   logic             at_max;
   logic             at_min;

   modport master (
      output clr, en, up_dn, load, load_val,
      input  count, tc, load_err, at_max, at_min
   );

   modport slave (
      input  clr, en, up_dn, load, load_val,
      output count, tc, load_err, at_max, at_min
   );
endinterface

// File: rtl/updown_counter_param.sv
// Modulo-MOD up/down counter with clear, parallel load and wrap or saturate mode.
// The terminal-count and illegal-load pulses are registered; the boundary flags decode count directly.
module updown_counter_param #(
   parameter int WIDTH     = 5,
   parameter int MOD       = 32,
   parameter int SATURATE  = 0,
   parameter int RESET_VAL = 0
) (
   input logic                  clk,
   input logic                  rst_n,
   updown_counter_param_if.slave bus
);
   localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MOD - 1);
   localparam logic [WIDTH-1:0] RST_VAL  = WIDTH'(RESET_VAL);
   localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MOD);
   localparam logic             SAT_MODE = (SATURATE != 0);

   logic [WIDTH-1:0] count_r;
   logic [WIDTH-1:0] count_nxt_s;
   logic             tc_r;
   logic             tc_nxt_s;
   logic             load_err_r;
   logic             load_err_nxt_s;
   logic             at_max_s;
   logic             at_min_s;
   logic             load_ok_s;

   // Wrap or hold at MOD-1, so the count never leaves 0..MOD-1 even when MOD < 2**WIDTH.
   function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] cur);
      logic [WIDTH-1:0] res;
      if (cur == MAX_VAL) begin
         res = SAT_MODE ? MAX_VAL : {WIDTH{1'b0}};
      end else begin
         res = cur + WIDTH'(1);
      end
      return res;
   endfunction

   function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] cur);
      logic [WIDTH-1:0] res;
      if (cur == {WIDTH{1'b0}}) begin
         res = SAT_MODE ? {WIDTH{1'b0}} : MAX_VAL;
      end else begin
         res = cur - WIDTH'(1);
      end
      return res;
   endfunction

   assign at_max_s  = (count_r == MAX_VAL);
   assign at_min_s  = (count_r == {WIDTH{1'b0}});
   // Extra top bit keeps the compare correct when MOD == 2**WIDTH.
   assign load_ok_s = ({1'b0, bus.load_val} < MOD_EXT);

   // Next-state decode with priority clr > load > en > hold.
   always_comb begin
      count_nxt_s    = count_r;
      tc_nxt_s       = 1'b0;
      load_err_nxt_s = 1'b0;
      if (bus.clr) begin
         count_nxt_s = RST_VAL;
      end else if (bus.load) begin
         if (load_ok_s) begin
            count_nxt_s = bus.load_val;
         end else begin
            load_err_nxt_s = 1'b1;
         end
      end else if (bus.en) begin
         if (bus.up_dn) begin
            count_nxt_s = step_up(count_r);
            tc_nxt_s    = at_max_s;
         end else begin
            count_nxt_s = step_down(count_r);
            tc_nxt_s    = at_min_s;
         end
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Count and pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r    <= RST_VAL;
         tc_r       <= 1'b0;
         load_err_r <= 1'b0;
      end else begin
         count_r    <= count_nxt_s;
         tc_r       <= tc_nxt_s;
         load_err_r <= load_err_nxt_s;
      end
   end

   assign bus.count    = count_r;
   assign bus.tc       = tc_r;
   assign bus.load_err = load_err_r;
   assign bus.at_max   = at_max_s;
   assign bus.at_min   = at_min_s;
endmodule
